// File: rtl/regfile_sb.sv
// 31-entry register file (r0 hardwired to zero) with write-through bypass and a
// per-register busy scoreboard used by decode to stall on deferred results.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic             we,
  input  logic [4:0]       wn,
  input  logic [WIDTH-1:0] d,
  input  logic             iss,
  input  logic [4:0]       iss_rn,
  output logic             busy_a,
  output logic             busy_b,
  output logic             stall
);

  localparam logic BYP = (BYPASS != 0);

  logic [WIDTH-1:0] word [32];
  logic [31:0]      sb;

  assign word[0] = '0;
  assign sb[0]   = 1'b0;

  // Each register owns its data and busy bit; an issue to the same register
  // as a write-back in one cycle leaves it busy because the set is applied last.
  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             busy_reg;
    logic             busy_next;

    always_comb begin
      data_next = data_reg;
      busy_next = busy_reg;
      if (we && (wn == 5'(gi))) begin
        data_next = d;
        busy_next = 1'b0;
      end
      if (iss && (iss_rn == 5'(gi))) begin
        busy_next = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        data_reg <= '0;
        busy_reg <= 1'b0;
      end else begin
        data_reg <= data_next;
        busy_reg <= busy_next;
      end
    end

    assign word[gi] = data_reg;
    assign sb[gi]   = busy_reg;
  end

  logic [4:0]       rn   [2];
  logic [WIDTH-1:0] q    [2];
  logic             busy [2];

  assign rn[0] = rna;
  assign rn[1] = rnb;

  // A write landing this cycle both supplies the data and resolves the hazard.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic hit;

    always_comb begin
      hit      = BYP && we && (wn == rn[gi]);
      q[gi]    = '0;
      busy[gi] = 1'b0;
      if (rn[gi] != 5'd0) begin
        q[gi]    = hit ? d : word[rn[gi]];
        busy[gi] = sb[rn[gi]] && !hit;
      end
    end
  end

  assign qa     = q[0];
  assign qb     = q[1];
  assign busy_a = busy[0];
  assign busy_b = busy[1];
  assign stall  = busy[0] | busy[1];

endmodule
